// File: rtl/encoder_display_ctrl.sv
// encoder_display_ctrl
//   Switch priority encoder with a decimal seven-segment readout.
//   The switch vector is synchronised and debounced, then priority-encoded
//   (MSB-first or LSB-first). The winning index is converted to BCD by a
//   sequential shift-add-3 engine and shown on DIGITS active-low displays
//   with leading-zero blanking.
//
// Ports
//   clk            clock
//   rst            asynchronous reset, active low
//   sw_toggle      raw switch vector (IN_W bits)
//   sw_en          raw encoder enable
//   sw_mode        raw priority mode: 0 = highest set bit wins, 1 = lowest
//   sw_hold        raw freeze request for the displayed result
//   led_outputs    registered encoded index ($clog2(IN_W) bits)
//   led_indicator  registered: enabled and at least one bit set
//   busy           high while a conversion is in progress
//   seg            display i in seg[8i+7:8i]; bit0..6 = a..g, bit7 = dp (1)
module encoder_display_ctrl #(
  parameter int unsigned IN_W      = 8,
  parameter int unsigned DIGITS    = 8,
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [IN_W-1:0]          sw_toggle,
  input  logic                     sw_en,
  input  logic                     sw_mode,
  input  logic                     sw_hold,
  output logic [$clog2(IN_W)-1:0]  led_outputs,
  output logic                     led_indicator,
  output logic                     busy,
  output logic [DIGITS*8-1:0]      seg
);

  localparam int unsigned OUT_W = $clog2(IN_W);

  // Decimal digits needed for the largest encodable index.
  function automatic int unsigned calc_ndig(input int unsigned w);
    int unsigned m;
    int unsigned n;
    m = (32'd1 << w) - 32'd1;
    n = 1;
    while (m >= 10) begin
      m = m / 10;
      n = n + 1;
    end
    return n;
  endfunction

  localparam int unsigned NDIG  = calc_ndig(OUT_W);
  localparam int unsigned BCD_W = 4 * NDIG;
  localparam int unsigned PADN  = (DIGITS > NDIG) ? DIGITS : NDIG;
  localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int unsigned CW    = $clog2(OUT_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  // Segment pattern a..g (active low) for one BCD digit.
  function automatic logic [6:0] enc7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Synchronisers and debounce
  logic [IN_W-1:0]  sw_meta_q, sw_sync_q;
  logic [2:0]       ctl_meta_q, ctl_sync_q;   // {hold, mode, en}
  logic [IN_W-1:0]  cand_q, stable_q;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic             commit;
  logic             en_s, mode_s, hold_s;

  assign en_s   = ctl_sync_q[0];
  assign mode_s = ctl_sync_q[1];
  assign hold_s = ctl_sync_q[2];

  // db_cnt_d counts matching samples beyond the first; a vector is committed
  // once DB_CYCLES consecutive identical samples have been seen, which also
  // makes DB_CYCLES=1 a plain register stage.
  always_comb begin
    db_cnt_d = '0;
    if (sw_sync_q == cand_q) begin
      db_cnt_d = db_cnt_q;
      if (db_cnt_q != CNT_W'(DB_CYCLES - 1)) db_cnt_d = db_cnt_q + 1'b1;
    end
    commit = (32'(db_cnt_d) >= DB_CYCLES - 1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      ctl_meta_q <= '0;
      ctl_sync_q <= '0;
      cand_q     <= '0;
      db_cnt_q   <= '0;
      stable_q   <= '0;
    end else begin
      sw_meta_q  <= sw_toggle;
      sw_sync_q  <= sw_meta_q;
      ctl_meta_q <= {sw_hold, sw_mode, sw_en};
      ctl_sync_q <= ctl_meta_q;
      cand_q     <= sw_sync_q;
      db_cnt_q   <= db_cnt_d;
      if (commit) stable_q <= sw_sync_q;
    end
  end

  // Priority encoder: the last hit of the scan wins
  logic [OUT_W-1:0] code;
  logic             valid;

  always_comb begin
    code = '0;
    for (int unsigned i = 0; i < IN_W; i++) begin
      if (!mode_s) begin
        if (stable_q[i]) code = OUT_W'(i);
      end else begin
        if (stable_q[IN_W-1-i]) code = OUT_W'(IN_W-1-i);
      end
    end
    if (!en_s) code = '0;
    valid = en_s & (|stable_q);
  end

  // Conversion FSM state
  state_e              state_q;
  logic                force_q;
  logic                snap_en_q, snap_valid_q;
  logic [OUT_W-1:0]    snap_code_q;
  logic [OUT_W-1:0]    sh_q, sh_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic [CW-1:0]       cnt_q;
  logic                busy_q;
  logic [OUT_W-1:0]    led_q;
  logic                ind_q;
  logic [DIGITS*8-1:0] seg_q, seg_d;

  // One double-dabble step: correct each nibble, then shift {bcd, sh} left.
  logic [BCD_W-1:0]       adj;
  logic [BCD_W+OUT_W-1:0] dd;

  always_comb begin
    adj = bcd_q;
    for (int unsigned k = 0; k < NDIG; k++) begin
      if (adj[4*k +: 4] >= 4'd5) adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
    end
    dd    = {adj, sh_q} << 1;
    bcd_d = dd[BCD_W+OUT_W-1:OUT_W];
    sh_d  = dd[OUT_W-1:0];
  end

  // Display bytes with leading-zero blanking; digit 0 is always shown.
  logic [4*PADN-1:0] bcd_pad;
  logic              shown;

  always_comb begin
    bcd_pad              = '0;
    bcd_pad[BCD_W-1:0]   = bcd_q;
    seg_d                = '1;
    shown                = 1'b0;
    if (snap_en_q) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        shown = (i == 0);
        for (int unsigned j = 0; j < PADN; j++) begin
          if (j >= i && bcd_pad[4*j +: 4] != 4'd0) shown = 1'b1;
        end
        if (shown) seg_d[8*i +: 8] = {1'b1, enc7(bcd_pad[4*i +: 4])};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      force_q      <= 1'b1;
      snap_en_q    <= 1'b0;
      snap_valid_q <= 1'b0;
      snap_code_q  <= '0;
      sh_q         <= '0;
      bcd_q        <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      led_q        <= '0;
      ind_q        <= 1'b0;
      seg_q        <= '1;
    end else begin
      case (state_q)
        IDLE: begin
          if (!hold_s && (force_q ||
              {en_s, valid, code} != {snap_en_q, snap_valid_q, snap_code_q})) begin
            snap_en_q    <= en_s;
            snap_valid_q <= valid;
            snap_code_q  <= code;
            sh_q         <= code;
            bcd_q        <= '0;
            cnt_q        <= CW'(OUT_W);
            busy_q       <= 1'b1;
            state_q      <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_q <= bcd_d;
          sh_q  <= sh_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_q <= DONE;
        end
        DONE: begin
          led_q   <= snap_code_q;
          ind_q   <= snap_valid_q;
          seg_q   <= seg_d;
          force_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign led_outputs   = led_q;
  assign led_indicator = ind_q;
  assign busy          = busy_q;
  assign seg           = seg_q;

endmodule

// File: doc/encoder_display_ctrl.md
Name: encoder_display_ctrl

Overview:
- Parametrised, registered successor to the 8-to-3 switch priority encoder with seven-segment readout.
- Synchronises and debounces an IN_W-bit switch vector, then priority-encodes it with selectable MSB-first or LSB-first priority.
- Converts the encoded index to decimal with a sequential shift-add-3 (double-dabble) FSM and drives DIGITS seven-segment displays with leading-zero blanking.
- Sits between board switches and the LED/segment pins in the NPC board top.

Parameters:
IN_W, 8, switch vector width; legal 2..64; OUT_W = clog2(IN_W) (localparam)
DIGITS, 8, number of seven-segment displays driven; legal >= 1
DB_CYCLES, 4, consecutive identical synchronised samples required to commit a new switch vector; legal >= 1

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
sw_toggle  in  IN_W  raw switch vector
sw_en  in  1  encoder enable (raw)
sw_mode  in  1  priority mode (raw): 0 = highest set bit wins, 1 = lowest set bit wins
sw_hold  in  1  freeze displayed result (raw)
led_outputs  out  OUT_W  registered encoded index
led_indicator  out  1  registered: enabled and at least one bit set
busy  out  1  high while a conversion is in progress
seg  out  DIGITS*8  display i in seg[8i+7:8i]; active-low; bit0..6 = segments a..g, bit7 = dp (always 1)

Behaviour:
- Reset (rst=0, asynchronous): led_outputs=0, led_indicator=0, busy=0, every seg byte=8'hFF. Synchronisers, debounce candidate and stable vector cleared to 0. FSM=IDLE. Force flag set, so one conversion runs after reset release.
- Sync: 2-FF synchronisers on sw_toggle, sw_en, sw_mode, sw_hold.
- Debounce (vector only):
  - Synchronised vector != candidate: load candidate, clear counter.
  - Otherwise increment the counter, saturating.
  - Counter reaching DB_CYCLES-1 with a matching sample: commit candidate to the stable vector. Shorter pulses are never committed.
- Encode (combinational on the stable vector and synchronised en/mode):
  - code = index of the winning set bit; 0 if no bit set or en=0.
  - valid = en & |stable.
- FSM:
  - IDLE: if hold=0 and (force, or {en,valid,code} differs from the last displayed snapshot): latch snapshot, shift reg=code, BCD=0, count=OUT_W, busy=1, go to SHIFT. Otherwise stay.
  - SHIFT: per cycle, add 3 to each BCD nibble >= 5, then shift {BCD,shift reg} left by 1 and decrement count. When count reaches 0, go to DONE.
  - DONE: register led_outputs=code, led_indicator=valid and all seg bytes. Clear force and busy. Return to IDLE.
- Inputs changing during SHIFT/DONE do not abort the conversion; the mismatch is picked up on the next IDLE cycle.
- Latency: from a stable switch change to updated outputs is at most 2 + DB_CYCLES + 1 + OUT_W + 1 cycles.
- Hold=1 in IDLE: no new conversion starts; outputs stay frozen. Hold asserted mid-conversion: that conversion completes.
- Display rules:
  - en=0: all bytes 8'hFF.
  - en=1: digit 0 (ones) always shown, including '0' when no bit set.
  - Digit i>0 shown only if it or any higher BCD digit is non-zero; otherwise 8'hFF.
  - Digits beyond the BCD width, or beyond DIGITS, are 8'hFF. BCD digits beyond DIGITS are dropped.
- Codes 0..9: C0 F9 A4 B0 99 92 82 F8 80 90.

Test Plan:
- Default params; sw_toggle=0x90, en=1, mode=0, hold=0, held steady -> within 12 cycles: led_outputs=7, led_indicator=1, seg[7:0]=0xF8, all other bytes 0xFF, busy pulses high for OUT_W+1=4 cycles.
- Same vector, mode=1 -> led_outputs=4, seg[7:0]=0x99; sw_toggle=0x00 -> led_outputs=0, led_indicator=0, seg[7:0]=0xC0.
- 0x01 stable, then a 0x80 glitch for 3 cycles (< DB_CYCLES) -> outputs stay at led_outputs=0, seg[7:0]=0xC0, no busy pulse. 0x80 held for 6 cycles -> led_outputs=7.
- hold=1, then sw_toggle 0x04 -> 0x40 -> outputs remain index 2 / 0xA4. Release hold -> index 6 / 0x82 within OUT_W+4 cycles of release (plus sync).
- IN_W=16, DIGITS=4, sw_toggle=0x8000, mode=0 -> led_outputs=15, seg[7:0]=0x92, seg[15:8]=0xF9, seg[31:16]=0xFFFF. en=0 -> all 0xFF, led_indicator=0, led_outputs=0.
- Assert rst mid-SHIFT -> immediately led_outputs=0, busy=0, all seg=0xFF. After release with switches unchanged -> the forced conversion restores correct outputs.
